// File: rtl/formic_bctl_pkg.sv
// Shared types and constants for the board-controller write-back arbiter.
// One-hot FSM encodings, owner encodings and the default burst length.
package formic_bctl_pkg;

  localparam int unsigned BURST_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_BURST = 3'b100
  } state_e;

  typedef enum logic {
    OWN_TRC = 1'b0,
    OWN_AUX = 1'b1
  } owner_e;

endpackage

// File: rtl/formic_bctl_wb_arb_if.sv
// Requester and L2C write-back signals of the arbiter, bundled in one interface.
// The master modport is the arbiter side; the slave modport is the FIFO/L2C side.
interface formic_bctl_wb_arb_if;
  logic        i_trc_req;
  logic [31:0] i_trc_adr;
  logic [31:0] i_trc_data;
  logic        o_trc_gnt;
  logic        o_trc_deq;
  logic        i_aux_req;
  logic [31:0] i_aux_adr;
  logic [31:0] i_aux_data;
  logic        o_aux_gnt;
  logic        o_aux_deq;
  logic        i_l2c_wb_space;
  logic        o_l2c_wb_valid;
  logic [31:0] o_l2c_wb_adr;
  logic [31:0] o_l2c_wb_data;

  modport master (
    input  i_trc_req, i_trc_adr, i_trc_data,
    output o_trc_gnt, o_trc_deq,
    input  i_aux_req, i_aux_adr, i_aux_data,
    output o_aux_gnt, o_aux_deq,
    input  i_l2c_wb_space,
    output o_l2c_wb_valid, o_l2c_wb_adr, o_l2c_wb_data
  );

  modport slave (
    output i_trc_req, i_trc_adr, i_trc_data,
    input  o_trc_gnt, o_trc_deq,
    output i_aux_req, i_aux_adr, i_aux_data,
    input  o_aux_gnt, o_aux_deq,
    output i_l2c_wb_space,
    input  o_l2c_wb_valid, o_l2c_wb_adr, o_l2c_wb_data
  );
endinterface

// File: rtl/formic_bctl_wb_rr2.sv
// Two-input round-robin picker with trace-priority override.
// The last-owner register resets to aux so trace wins the first tie.
module formic_bctl_wb_rr2
  import formic_bctl_pkg::*;
(
  input  logic   clk_mc,
  input  logic   rst_mc,
  input  logic   req_trc_i,
  input  logic   req_aux_i,
  input  logic   prio_trc_i,
  input  logic   upd_i,
  input  owner_e own_i,
  output owner_e pick_o
);

  owner_e last_q;
  owner_e last_d;

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = own_i;
  end

  always_ff @(posedge clk_mc) begin
    if (rst_mc) last_q <= OWN_AUX;
    else        last_q <= last_d;
  end

  always_comb begin
    pick_o = OWN_TRC;
    if (req_trc_i && req_aux_i) begin
      if (prio_trc_i)             pick_o = OWN_TRC;
      else if (last_q == OWN_TRC) pick_o = OWN_AUX;
      else                        pick_o = OWN_TRC;
    end else if (req_aux_i) begin
      pick_o = OWN_AUX;
    end
  end

endmodule

// File: rtl/formic_bctl_wb_arb.sv
// Whole-burst arbiter sharing the L2C write-back channel between trace and aux.
// Grants one burst at a time, drives one aligned address and pops the owner's FIFO.
module formic_bctl_wb_arb
  import formic_bctl_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk_mc,
  input  logic                rst_mc,
  formic_bctl_wb_arb_if.master bus,
  input  logic                i_arb_trc_prio,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_trc_bursts,
  output logic [CNT_W-1:0]    o_aux_bursts
);

  localparam int unsigned WC_W = $clog2(BURST_LEN);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            pick;
  logic [31:0]       adr_q, adr_d;
  logic [WC_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]  trc_cnt_q, trc_cnt_d;
  logic [CNT_W-1:0]  aux_cnt_q, aux_cnt_d;
  logic              req_any;
  logic              last_word;

  assign req_any   = bus.i_trc_req | bus.i_aux_req;
  assign last_word = (state_q == ST_BURST) && (word_q == WORD_LAST);

  formic_bctl_wb_rr2 u_rr2 (
    .clk_mc     (clk_mc),
    .rst_mc     (rst_mc),
    .req_trc_i  (bus.i_trc_req),
    .req_aux_i  (bus.i_aux_req),
    .prio_trc_i (i_arb_trc_prio),
    .upd_i      (state_q == ST_GRANT),
    .own_i      (owner_q),
    .pick_o     (pick)
  );

  always_ff @(posedge clk_mc) begin
    if (rst_mc) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_AUX;
      adr_q     <= '0;
      word_q    <= '0;
      trc_cnt_q <= '0;
      aux_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      adr_q     <= adr_d;
      word_q    <= word_d;
      trc_cnt_q <= trc_cnt_d;
      aux_cnt_q <= aux_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.i_l2c_wb_space && req_any) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_BURST;
      ST_BURST: if (word_q == WORD_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: owner chosen in Idle, address captured in Grant.
  always_comb begin
    owner_d   = owner_q;
    adr_d     = adr_q;
    word_d    = word_q;
    trc_cnt_d = trc_cnt_q;
    aux_cnt_d = aux_cnt_q;
    if (state_q == ST_IDLE && state_d == ST_GRANT) owner_d = pick;
    if (state_q == ST_GRANT) begin
      word_d = '0;
      adr_d  = ((owner_q == OWN_TRC) ? bus.i_trc_adr : bus.i_aux_adr) & 32'hFFFF_FFC0;
    end
    if (state_q == ST_BURST) word_d = word_q + 1'b1;
    if (last_word) begin
      if (owner_q == OWN_TRC) trc_cnt_d = trc_cnt_q + 1'b1;
      else                    aux_cnt_d = aux_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.o_trc_gnt      = 1'b0;
    bus.o_aux_gnt      = 1'b0;
    bus.o_trc_deq      = 1'b0;
    bus.o_aux_deq      = 1'b0;
    bus.o_l2c_wb_valid = 1'b0;
    bus.o_l2c_wb_data  = '0;
    o_busy             = (state_q != ST_IDLE);
    unique case (state_q)
      ST_GRANT: begin
        bus.o_trc_gnt = (owner_q == OWN_TRC);
        bus.o_aux_gnt = (owner_q == OWN_AUX);
      end
      ST_BURST: begin
        bus.o_l2c_wb_valid = 1'b1;
        bus.o_trc_deq      = (owner_q == OWN_TRC);
        bus.o_aux_deq      = (owner_q == OWN_AUX);
        bus.o_l2c_wb_data  = (owner_q == OWN_TRC) ? bus.i_trc_data : bus.i_aux_data;
      end
      default: ;
    endcase
  end

  assign bus.o_l2c_wb_adr = adr_q;
  assign o_trc_bursts     = trc_cnt_q;
  assign o_aux_bursts     = aux_cnt_q;

endmodule
